// File: rtl/gcd_if.sv
// Handshake and operand/result bundle for gcd_engine.
// The iter_cnt signal exists only when GCD_ITER_CNT_EN is defined.
interface gcd_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero_err;
`ifdef GCD_ITER_CNT_EN
   logic [WIDTH-1:0] iter_cnt;
`endif

   modport master (
      output start, a_in, b_in,
      input  busy, done, result, zero_err
`ifdef GCD_ITER_CNT_EN
      , input iter_cnt
`endif
   );

   modport slave (
      input  start, a_in, b_in,
      output busy, done, result, zero_err
`ifdef GCD_ITER_CNT_EN
      , output iter_cnt
`endif
   );
endinterface

// File: rtl/gcd_engine.sv
// Subtract-based Euclid GCD with start/busy/done handshake and zero-operand handling.
// Optional iteration counter output enabled by defining GCD_ITER_CNT_EN.
module gcd_engine #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   gcd_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] result_reg;
   logic             zero_err_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             operand_zero;
   logic             operands_equal;
   logic             finish;

   assign operand_zero   = (a_reg == '0) || (b_reg == '0);
   assign operands_equal = (a_reg == b_reg);
   // Zero operands are resolved in the first RUN cycle so every operation shares the same minimum latency.
   assign finish         = operand_zero || operands_equal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (finish) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg        <= '0;
         b_reg        <= '0;
         result_reg   <= '0;
         zero_err_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         busy_reg <= (state_next != IDLE);
         done_reg <= (state_next == DONE);
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  a_reg        <= bus.a_in;
                  b_reg        <= bus.b_in;
                  zero_err_reg <= 1'b0;
               end
            end
            RUN: begin
               if (finish) begin
                  // With one operand zero a|b is the other; with equal operands it is either one.
                  result_reg   <= a_reg | b_reg;
                  zero_err_reg <= (a_reg == '0) && (b_reg == '0);
               end else if (a_reg > b_reg) begin
                  a_reg <= a_reg - b_reg;
               end else begin
                  b_reg <= b_reg - a_reg;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef GCD_ITER_CNT_EN
   logic [WIDTH-1:0] iter_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iter_cnt_reg <= '0;
      end else if (state_reg == IDLE && bus.start) begin
         iter_cnt_reg <= '0;
      end else if (state_reg == RUN && !finish && iter_cnt_reg != '1) begin
         iter_cnt_reg <= iter_cnt_reg + 1'b1;
      end
   end

   assign bus.iter_cnt = iter_cnt_reg;
`endif

   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
   assign bus.result   = result_reg;
   assign bus.zero_err = zero_err_reg;
endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine (WIDTH=8): stimulus pushes expectations, a monitor checks each done pulse.
// Iteration counts are also checked when GCD_ITER_CNT_EN is defined.
module tb_gcd_engine;
   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             zerr;
      int               iters;
      int               acc_cyc;
      int               lat;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   errors;
   int   checks;
   exp_t sb_q[$];

   gcd_if #(.WIDTH(WIDTH)) bus ();

   gcd_engine #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (bus.busy && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2000) check("idle_timeout", 1, 0);
   endtask

   // Launch one operation; n = number of subtraction iterations (latency n+1).
   task automatic issue(input int a, input int b, input int res, input int zerr, input int n);
      exp_t e;
      wait_idle();
      bus.start = 1'b1;
      bus.a_in  = WIDTH'(a);
      bus.b_in  = WIDTH'(b);
      @(posedge clk);
      #1;
      e.res = WIDTH'(res); e.zerr = zerr[0]; e.iters = n; e.acc_cyc = cyc; e.lat = n + 1;
      sb_q.push_back(e);
      $display("issue a=%0d b=%0d expect result=%0d zero_err=%0d at cycle %0d", a, b, res, zerr, cyc);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_accept", int'(bus.busy), 1);
   endtask

   // Monitor: every done pulse pops one expectation; the cycle after must show held result and no done.
   initial begin
      exp_t e;
      logic             held_pending;
      logic [WIDTH-1:0] held_res;
      logic             held_zerr;
      held_pending = 1'b0;
      held_res     = '0;
      held_zerr    = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("result", int'(bus.result), int'(e.res));
               check("zero_err", int'(bus.zero_err), int'(e.zerr));
               check("latency", cyc - e.acc_cyc, e.lat);
`ifdef GCD_ITER_CNT_EN
               check("iter_cnt", int'(bus.iter_cnt), e.iters);
`endif
               $display("done result=%0d zero_err=%0d latency=%0d", bus.result, bus.zero_err, cyc - e.acc_cyc);
               held_pending = 1'b1;
               held_res     = e.res;
               held_zerr    = e.zerr;
            end
         end else if (held_pending) begin
            held_pending = 1'b0;
            check("result_held", int'(bus.result), int'(held_res));
            check("zero_err_held", int'(bus.zero_err), int'(held_zerr));
         end
      end
   end

   initial begin
      exp_t e;
      int   c0;
      int   k;
      errors = 0;
      checks = 0;
      cyc    = 0;
      rst_n  = 1'b0;
      bus.start = 1'b0;
      bus.a_in  = '0;
      bus.b_in  = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_result", int'(bus.result), 0);
      check("reset_zero_err", int'(bus.zero_err), 0);
`ifdef GCD_ITER_CNT_EN
      check("reset_iter_cnt", int'(bus.iter_cnt), 0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      issue(12, 18, 6, 0, 2);
      issue(7, 7, 7, 0, 0);
      issue(0, 9, 9, 0, 0);
      issue(9, 0, 9, 0, 0);
      issue(0, 0, 0, 1, 0);
      issue(13, 8, 1, 0, 5);
      issue(255, 17, 17, 0, 14);
      issue(1, 255, 1, 0, 254);

      // Start held through a whole run; operands changed while busy must not be recaptured.
      wait_idle();
      bus.start = 1'b1;
      bus.a_in  = 8'd12;
      bus.b_in  = 8'd18;
      @(posedge clk);
      #1;
      c0 = cyc;
      e.res = 8'd6; e.zerr = 1'b0; e.iters = 2; e.acc_cyc = c0; e.lat = 3;
      sb_q.push_back(e);
      $display("issue held-start a=12 b=18 expect result=6 at cycle %0d", c0);
      @(negedge clk);
      bus.a_in = 8'd48;
      bus.b_in = 8'd36;
      k = 0;
      while (cyc < c0 + 5 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      e.res = 8'd12; e.zerr = 1'b0; e.iters = 3; e.acc_cyc = c0 + 5; e.lat = 4;
      sb_q.push_back(e);
      $display("held-start second op a=48 b=36 expect result=12 accepted at cycle %0d", c0 + 5);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_second_op", int'(bus.busy), 1);

      // Abort a long run with an asynchronous reset; no completion may be reported.
      wait_idle();
      bus.start = 1'b1;
      bus.a_in  = 8'd1;
      bus.b_in  = 8'd255;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(bus.busy), 0);
      check("abort_result", int'(bus.result), 0);
      check("abort_zero_err", int'(bus.zero_err), 0);
      check("abort_done", int'(bus.done), 0);
      $display("reset asserted mid-run at cycle %0d", cyc);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(48, 36, 12, 0, 3);

      k = 0;
      while (sb_q.size() != 0 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2000) check("drain_timeout", 1, 0);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
